// File: rtl/branch_rs.sv
// Reservation station for the branch functional unit: a collapsing queue with
// entry 0 as the oldest op. It wakes sources from the CDB and issues the oldest ready op each cycle.
module branch_rs #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 6,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_opcode,
  input  logic [2:0]       disp_branch_type,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [XLEN-1:0]  disp_offset,
  input  logic [TAG_W-1:0] disp_rob_tag,
  input  logic             disp_rs1_rdy,
  input  logic [XLEN-1:0]  disp_rs1_val,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic             disp_rs2_rdy,
  input  logic [XLEN-1:0]  disp_rs2_val,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             issue_valid,
  output logic [4:0]       issue_opcode,
  output logic [2:0]       issue_branch_type,
  output logic [XLEN-1:0]  issue_rs1,
  output logic [XLEN-1:0]  issue_rs2,
  output logic [XLEN-1:0]  issue_pc,
  output logic [XLEN-1:0]  issue_offset,
  output logic [TAG_W-1:0] issue_rob_tag,
  output logic [CNT_W-1:0] occupancy
);

  typedef struct packed {
    logic             vld;
    logic [4:0]       opcode;
    logic [2:0]       btype;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  offset;
    logic [TAG_W-1:0] rob_tag;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [XLEN-1:0]  rs2_val;
    logic [TAG_W-1:0] rs2_tag;
  } entry_t;

  entry_t           ent_q [ENTRIES];
  entry_t           ent_d [ENTRIES];
  // One spare slot past the top so the shift-down reads an empty entry.
  entry_t           woke  [ENTRIES+1];
  entry_t           disp_ent;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             iv_q, iv_d;
  logic [4:0]       iop_q, iop_d;
  logic [2:0]       ibt_q, ibt_d;
  logic [XLEN-1:0]  irs1_q, irs1_d, irs2_q, irs2_d, ipc_q, ipc_d, ioff_q, ioff_d;
  logic [TAG_W-1:0] irob_q, irob_d;
  logic             sel_found, disp_fire;
  int               sel_idx, widx;

  assign disp_ready = (occ_q != CNT_W'(ENTRIES));
  assign disp_fire  = disp_valid && disp_ready && !flush;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 0;
    iop_d  = iop_q;
    ibt_d  = ibt_q;
    irs1_d = irs1_q;
    irs2_d = irs2_q;
    ipc_d  = ipc_q;
    ioff_d = ioff_q;
    irob_d = irob_q;
    // Select looks only at stored readiness; a broadcast this cycle counts next cycle.
    for (int i = 0; i < ENTRIES; i++) begin
      if (!sel_found && ent_q[i].vld && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = i;
        iop_d  = ent_q[i].opcode;
        ibt_d  = ent_q[i].btype;
        irs1_d = ent_q[i].rs1_val;
        irs2_d = ent_q[i].rs2_val;
        ipc_d  = ent_q[i].pc;
        ioff_d = ent_q[i].offset;
        irob_d = ent_q[i].rob_tag;
      end
    end

    for (int i = 0; i < ENTRIES; i++) begin
      woke[i] = ent_q[i];
      if (cdb_valid && ent_q[i].vld && !ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_tag) begin
        woke[i].rs1_rdy = 1'b1;
        woke[i].rs1_val = cdb_value;
      end
      if (cdb_valid && ent_q[i].vld && !ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_tag) begin
        woke[i].rs2_rdy = 1'b1;
        woke[i].rs2_val = cdb_value;
      end
    end
    woke[ENTRIES] = '0;

    disp_ent = '{vld: 1'b1, opcode: disp_opcode, btype: disp_branch_type, pc: disp_pc,
                 offset: disp_offset, rob_tag: disp_rob_tag,
                 rs1_rdy: disp_rs1_rdy, rs1_val: disp_rs1_val, rs1_tag: disp_rs1_tag,
                 rs2_rdy: disp_rs2_rdy, rs2_val: disp_rs2_val, rs2_tag: disp_rs2_tag};
    if (cdb_valid && !disp_rs1_rdy && disp_rs1_tag == cdb_tag) begin
      disp_ent.rs1_rdy = 1'b1;
      disp_ent.rs1_val = cdb_value;
    end
    if (cdb_valid && !disp_rs2_rdy && disp_rs2_tag == cdb_tag) begin
      disp_ent.rs2_rdy = 1'b1;
      disp_ent.rs2_val = cdb_value;
    end

    widx = int'(occ_q) - (sel_found ? 1 : 0);
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = (sel_found && i >= sel_idx) ? woke[i+1] : woke[i];
      if (disp_fire && i == widx) ent_d[i] = disp_ent;
    end

    occ_d = occ_q + CNT_W'(disp_fire) - CNT_W'(sel_found);
    iv_d  = sel_found;

    // Flush wins over everything; the issue payload simply holds.
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent_d[i] = '0;
      occ_d  = '0;
      iv_d   = 1'b0;
      iop_d  = iop_q;
      ibt_d  = ibt_q;
      irs1_d = irs1_q;
      irs2_d = irs2_q;
      ipc_d  = ipc_q;
      ioff_d = ioff_q;
      irob_d = irob_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      occ_q  <= '0;
      iv_q   <= 1'b0;
      iop_q  <= '0;
      ibt_q  <= '0;
      irs1_q <= '0;
      irs2_q <= '0;
      ipc_q  <= '0;
      ioff_q <= '0;
      irob_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
      occ_q  <= occ_d;
      iv_q   <= iv_d;
      iop_q  <= iop_d;
      ibt_q  <= ibt_d;
      irs1_q <= irs1_d;
      irs2_q <= irs2_d;
      ipc_q  <= ipc_d;
      ioff_q <= ioff_d;
      irob_q <= irob_d;
    end
  end

  assign issue_valid       = iv_q;
  assign issue_opcode      = iop_q;
  assign issue_branch_type = ibt_q;
  assign issue_rs1         = irs1_q;
  assign issue_rs2         = irs2_q;
  assign issue_pc          = ipc_q;
  assign issue_offset      = ioff_q;
  assign issue_rob_tag     = irob_q;
  assign occupancy         = occ_q;

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_branch_rs;
  localparam int XLEN = 32, ENTRIES = 4, TAG_W = 6, CNT_W = $clog2(ENTRIES + 1);

  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready;
  logic [4:0] disp_opcode;
  logic [2:0] disp_branch_type;
  logic [31:0] disp_pc, disp_offset, disp_rs1_val, disp_rs2_val, cdb_value;
  logic [5:0] disp_rob_tag, disp_rs1_tag, disp_rs2_tag, cdb_tag;
  logic disp_rs1_rdy, disp_rs2_rdy, cdb_valid;
  logic issue_valid;
  logic [4:0] issue_opcode;
  logic [2:0] issue_branch_type;
  logic [31:0] issue_rs1, issue_rs2, issue_pc, issue_offset;
  logic [5:0] issue_rob_tag;
  logic [CNT_W-1:0] occupancy;

  always #5 clk = ~clk;

  branch_rs #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_branch_type(disp_branch_type),
    .disp_pc(disp_pc), .disp_offset(disp_offset), .disp_rob_tag(disp_rob_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_branch_type(issue_branch_type), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_pc(issue_pc), .issue_offset(issue_offset), .issue_rob_tag(issue_rob_tag),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  bt;
    logic [31:0] pc, off;
    logic [5:0]  rob;
    bit          r1;
    logic [31:0] v1;
    logic [5:0]  t1;
    bit          r2;
    logic [31:0] v2;
    logic [5:0]  t2;
  } op_t;

  op_t mq[$];
  bit  m_iv;
  op_t m_iss;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: program-order list of waiting ops; oldest ready one leaves each cycle.
  always @(posedge clk or posedge rst) begin
    int  s;
    bit  acc;
    op_t e;
    op_t n;
    if (rst) begin
      mq.delete();
      m_iv  = 1'b0;
      m_iss = '{default: '0};
    end else if (flush) begin
      mq.delete();
      m_iv = 1'b0;
    end else begin
      s = -1;
      for (int i = 0; i < mq.size(); i++)
        if (s < 0 && mq[i].r1 && mq[i].r2) s = i;
      acc = disp_valid && (mq.size() != ENTRIES);
      if (cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          if (!e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_value; end
          if (!e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_value; end
          mq[i] = e;
        end
      end
      if (s >= 0) begin
        m_iss = mq[s];
        m_iv  = 1'b1;
        mq.delete(s);
      end else begin
        m_iv = 1'b0;
      end
      if (acc) begin
        n.op = disp_opcode; n.bt = disp_branch_type; n.pc = disp_pc; n.off = disp_offset;
        n.rob = disp_rob_tag;
        n.r1 = disp_rs1_rdy; n.v1 = disp_rs1_val; n.t1 = disp_rs1_tag;
        n.r2 = disp_rs2_rdy; n.v2 = disp_rs2_val; n.t2 = disp_rs2_tag;
        if (cdb_valid && !n.r1 && n.t1 == cdb_tag) begin n.r1 = 1'b1; n.v1 = cdb_value; end
        if (cdb_valid && !n.r2 && n.t2 == cdb_tag) begin n.r2 = 1'b1; n.v2 = cdb_value; end
        mq.push_back(n);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_issue_valid", 64'(issue_valid), 64'(m_iv));
      chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
      chk("m_disp_ready", 64'(disp_ready), 64'(mq.size() != ENTRIES));
      chk("m_opcode", 64'(issue_opcode), 64'(m_iss.op));
      chk("m_btype", 64'(issue_branch_type), 64'(m_iss.bt));
      chk("m_rs1", 64'(issue_rs1), 64'(m_iss.v1));
      chk("m_rs2", 64'(issue_rs2), 64'(m_iss.v2));
      chk("m_pc", 64'(issue_pc), 64'(m_iss.pc));
      chk("m_offset", 64'(issue_offset), 64'(m_iss.off));
      chk("m_rob", 64'(issue_rob_tag), 64'(m_iss.rob));
    end
  end

  task automatic idle_in();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] bt, input logic [31:0] pc,
                       input logic [31:0] off, input logic [5:0] rob,
                       input bit r1, input logic [31:0] v1, input logic [5:0] t1,
                       input bit r2, input logic [31:0] v2, input logic [5:0] t2);
    disp_valid = 1'b1; disp_opcode = op; disp_branch_type = bt; disp_pc = pc;
    disp_offset = off; disp_rob_tag = rob;
    disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    drive(5'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0);
    disp_valid = 1'b0;
    cdb_tag = 6'd0; cdb_value = 32'd0;
    #1;
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_rs1", 64'(issue_rs1), 64'd0);
    chk("rst_pc", 64'(issue_pc), 64'd0);
    chk("rst_rob", 64'(issue_rob_tag), 64'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Single BEQ, both sources ready
    drive(5'b11000, 3'b000, 32'h30000000, 32'hF, 6'd3, 1'b1, 32'h12345678, 6'd0, 1'b1, 32'h12345678, 6'd0);
    cyc(); idle_in();
    chk("beq_occ_after_disp", 64'(occupancy), 64'd1);
    chk("beq_iv_before", 64'(issue_valid), 64'd0);
    cyc();
    chk("beq_iv", 64'(issue_valid), 64'd1);
    chk("beq_rs1", 64'(issue_rs1), 64'h12345678);
    chk("beq_rs2", 64'(issue_rs2), 64'h12345678);
    chk("beq_pc", 64'(issue_pc), 64'h30000000);
    chk("beq_offset", 64'(issue_offset), 64'hF);
    chk("beq_rob", 64'(issue_rob_tag), 64'd3);
    chk("beq_opcode", 64'(issue_opcode), 64'b11000);
    chk("beq_occ", 64'(occupancy), 64'd0);
    cyc();
    chk("beq_iv_drop", 64'(issue_valid), 64'd0);

    // Younger ready op overtakes older waiting op
    drive(5'b11000, 3'b001, 32'h100, 32'h8, 6'd1, 1'b0, 32'd0, 6'd5, 1'b1, 32'd7, 6'd0);
    cyc();
    drive(5'b11000, 3'b100, 32'h104, 32'hC, 6'd2, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0);
    cyc(); idle_in();
    cdb(6'd5, 32'd25);
    cyc(); cdb_valid = 1'b0;
    chk("ab_first_iv", 64'(issue_valid), 64'd1);
    chk("ab_first_rob", 64'(issue_rob_tag), 64'd2);
    cyc();
    chk("ab_second_rob", 64'(issue_rob_tag), 64'd1);
    chk("ab_second_rs1", 64'(issue_rs1), 64'd25);
    cyc();

    // Fill to full, all waiting on tag 9
    for (int k = 0; k < 4; k++) begin
      drive(5'b11000, 3'd0, 32'h200 + 32'(k), 32'd4, 6'(10 + k), 1'b0, 32'd0, 6'd9, 1'b1, 32'(k), 6'd0);
      cyc();
    end
    idle_in();
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_ready", 64'(disp_ready), 64'd0);
    cdb(6'd9, 32'd99);
    drive(5'b11000, 3'd0, 32'h300, 32'd4, 6'd20, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0);
    cyc();
    chk("full_wake_iv", 64'(issue_valid), 64'd0);
    cdb_valid = 1'b0;
    drive(5'b11000, 3'd0, 32'h304, 32'd4, 6'd21, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle_in();
      chk("drain_iv", 64'(issue_valid), 64'd1);
      chk("drain_rob", 64'(issue_rob_tag), 64'(10 + k));
      chk("drain_rs1", 64'(issue_rs1), 64'd99);
    end
    cyc();

    // Dispatch-time CDB bypass
    drive(5'b11000, 3'd1, 32'h400, 32'd8, 6'd40, 1'b1, 32'd1, 6'd0, 1'b0, 32'd0, 6'd7);
    cdb(6'd7, 32'hFFFFFFE7);
    cyc(); idle_in();
    chk("byp_occ", 64'(occupancy), 64'd1);
    cyc();
    chk("byp_iv", 64'(issue_valid), 64'd1);
    chk("byp_rs2", 64'(issue_rs2), 64'hFFFFFFE7);

    // Both sources wake on one broadcast
    drive(5'b11000, 3'd5, 32'h500, 32'd8, 6'd41, 1'b0, 32'd0, 6'd3, 1'b0, 32'd0, 6'd3);
    cyc(); idle_in();
    cdb(6'd3, 32'd33);
    cyc(); cdb_valid = 1'b0;
    cyc();
    chk("both_rs1", 64'(issue_rs1), 64'd33);
    chk("both_rs2", 64'(issue_rs2), 64'd33);

    // Flush with three waiting entries and a simultaneous dispatch
    for (int k = 0; k < 3; k++) begin
      drive(5'b11000, 3'd0, 32'h600, 32'd4, 6'(50 + k), 1'b0, 32'd0, 6'd30, 1'b1, 32'd0, 6'd0);
      cyc();
    end
    idle_in();
    chk("pre_flush_occ", 64'(occupancy), 64'd3);
    drive(5'b11000, 3'd0, 32'h700, 32'd4, 6'd53, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0);
    cdb(6'd30, 32'd5);
    flush = 1'b1;
    cyc(); idle_in();
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_iv", 64'(issue_valid), 64'd0);
    chk("flush_ready", 64'(disp_ready), 64'd1);
    cyc();
    chk("flush_discard_iv", 64'(issue_valid), 64'd0);

    // Mixed traffic checked by the model
    for (int c = 0; c < 300; c++) begin
      idle_in();
      if ($urandom_range(0, 2) != 0)
        drive(5'($urandom), 3'($urandom), $urandom, $urandom, 6'($urandom),
              1'($urandom), $urandom, 6'($urandom_range(0, 3)),
              1'($urandom), $urandom, 6'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) != 0) cdb(6'($urandom_range(0, 3)), $urandom);
      flush = ($urandom_range(0, 29) == 0);
      cyc();
    end
    idle_in();
    flush = 1'b1;
    cyc(); idle_in();

    // Asynchronous reset in the middle of activity
    drive(5'b11000, 3'd0, 32'h800, 32'd4, 6'd60, 1'b1, 32'hAA, 6'd0, 1'b1, 32'd0, 6'd0);
    cyc();
    drive(5'b11000, 3'd0, 32'h804, 32'd4, 6'd61, 1'b0, 32'd0, 6'd40, 1'b1, 32'd0, 6'd0);
    cyc(); idle_in();
    chk("mid_iv", 64'(issue_valid), 64'd1);
    chk("mid_occ", 64'(occupancy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_iv", 64'(issue_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_ready", 64'(disp_ready), 64'd1);
    chk("arst_rs1", 64'(issue_rs1), 64'd0);
    chk("arst_rob", 64'(issue_rob_tag), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_iv", 64'(issue_valid), 64'd0);
    chk("post_rst_occ", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
